// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: N-LED rotate-left/right, bounce and binary count
// patterns stepped by a clock divider or by single-step requests while paused.
module led_pattern_seq #(
  parameter int NUM_LEDS = 4,
  parameter int CLK_HZ   = 100000000,
  parameter int STEP_HZ  = 1,
  parameter int SIM_MODE = 0,
  parameter int SIM_DIV  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic                run,
  input  logic                step_req,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick,
  output logic                wrap
);

  localparam int DIV   = (SIM_MODE != 0) ? SIM_DIV : (CLK_HZ / STEP_HZ);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e                mode_q, mode_d;
  dir_e                 dir_q, dir_d, dirStep;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]  led_q, led_d, ledStep;
  logic                 stepReq_q;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 stepEdge;
  logic                 adv;
  logic                 modeChg;

  function automatic logic [NUM_LEDS-1:0] startVal(input mode_e m);
    return (m == COUNT) ? '0 : NUM_LEDS'(1);
  endfunction

  // Candidate next pattern value for the currently registered mode.
  always_comb begin
    ledStep = led_q;
    dirStep = dir_q;
    case (mode_q)
      ROT_L:   ledStep = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
      ROT_R:   ledStep = {led_q[0], led_q[NUM_LEDS-1:1]};
      BOUNCE: begin
        if (dir_q == DIR_UP) begin
          ledStep = led_q << 1;
          dirStep = ledStep[NUM_LEDS-1] ? DIR_DOWN : DIR_UP;
        end else begin
          ledStep = led_q >> 1;
          dirStep = ledStep[0] ? DIR_UP : DIR_DOWN;
        end
      end
      COUNT:   ledStep = led_q + NUM_LEDS'(1);
      default: ledStep = led_q;
    endcase
  end

  always_comb begin
    stepEdge = step_req & ~stepReq_q & ~run;
    adv      = run ? (cnt_q == CNT_MAX) : stepEdge;
    modeChg  = (mode_e'(mode) != mode_q);

    mode_d = mode_e'(mode);
    led_d  = led_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    cnt_d  = '0;
    if (run && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A mode change restarts the new pattern and wins over a coincident step.
    if (modeChg) begin
      led_d = startVal(mode_e'(mode));
      dir_d = DIR_UP;
      cnt_d = '0;
    end else if (adv) begin
      led_d  = ledStep;
      dir_d  = dirStep;
      tick_d = 1'b1;
      wrap_d = (ledStep == startVal(mode_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= startVal(mode_e'(mode));
      mode_q    <= mode_e'(mode);
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      stepReq_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      led_q     <= led_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      stepReq_q <= step_req;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed vector tables, hand-written corner
// sequences, and a randomized run against a step-index reference model.
module tb_led_pattern_seq;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         run;
  logic         step_req;
  logic [N-1:0] led;
  logic         tick;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: pattern is a pure function of mode and step index mK.
  int   mK = 0;
  int   mMode = 0;
  int   mDiv = 0;
  logic mPrevStep = 1'b0;
  logic mTick = 1'b0;
  logic mWrap = 1'b0;

  typedef struct {
    logic         rst;
    logic [1:0]   mode;
    logic         run;
    logic         stepReq;
    logic [N-1:0] led;
    logic         tick;
    logic         wrap;
  } vec_t;

  vec_t         vecs[$];
  logic [N-1:0] lastLed;
  logic [N-1:0] rotSeq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] bncSeq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  always #5 clk = ~clk;

  led_pattern_seq #(
    .NUM_LEDS(N),
    .CLK_HZ  (100000000),
    .STEP_HZ (1),
    .SIM_MODE(1),
    .SIM_DIV (DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .run     (run),
    .step_req(step_req),
    .led     (led),
    .tick    (tick),
    .wrap    (wrap)
  );

  function automatic int period(input int m);
    if (m == 2) return 2 * N - 2;
    if (m == 3) return 1 << N;
    return N;
  endfunction

  function automatic logic [N-1:0] patternAt(input int m, input int k);
    int p;
    case (m)
      0: return N'(1) << (k % N);
      1: return N'(1) << ((N - (k % N)) % N);
      2: begin
        p = k % (2 * N - 2);
        return N'(1) << ((p < N) ? p : (2 * N - 2 - p));
      end
      default: return N'(k % (1 << N));
    endcase
  endfunction

  function automatic vec_t mkVec(input logic r, input logic [1:0] m, input logic rn,
                                 input logic sr, input logic [N-1:0] l,
                                 input logic t, input logic w);
    vec_t v;
    v.rst = r; v.mode = m; v.run = rn; v.stepReq = sr;
    v.led = l; v.tick = t; v.wrap = w;
    return v;
  endfunction

  // Drive inputs away from the edge, update the model on the edge, return at negedge.
  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic rn, input logic sr);
    logic adv;
    reset = r; mode = m; run = rn; step_req = sr;
    @(posedge clk);
    if (r) begin
      mK = 0; mMode = int'(m); mDiv = 0; mPrevStep = 1'b0; mTick = 1'b0; mWrap = 1'b0;
    end else if (int'(m) != mMode) begin
      mK = 0; mMode = int'(m); mDiv = 0; mPrevStep = sr; mTick = 1'b0; mWrap = 1'b0;
    end else begin
      adv  = rn ? (mDiv == DIV - 1) : (sr && !mPrevStep);
      mDiv = rn ? (mDiv + 1) % DIV : 0;
      if (adv) begin
        mK    = (mK + 1) % period(mMode);
        mTick = 1'b1;
        mWrap = (mK == 0);
      end else begin
        mTick = 1'b0;
        mWrap = 1'b0;
      end
      mPrevStep = sr;
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eLed,
                             input logic eTick, input logic eWrap);
    checks++;
    if (led !== eLed || tick !== eTick || wrap !== eWrap) begin
      errors++;
      $display("[TB] FAIL %s: got led=%b tick=%b wrap=%b, expected led=%b tick=%b wrap=%b",
               name, led, tick, wrap, eLed, eTick, eWrap);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] m, input logic rn, input logic sr,
                     input logic [N-1:0] eLed, input logic eTick, input logic eWrap,
                     input string name);
    applyStimulus(r, m, rn, sr);
    checkOutput(name, eLed, eTick, eWrap);
  endtask

  // DIV-1 quiet cycles at the held value, then the new value with a tick.
  task automatic runStep(input logic [1:0] m, input logic [N-1:0] newLed,
                         input logic isWrap, input string name);
    for (int i = 0; i < DIV - 1; i++) cyc(1'b0, m, 1'b1, 1'b0, lastLed, 1'b0, 1'b0, {name, " hold"});
    cyc(1'b0, m, 1'b1, 1'b0, newLed, 1'b1, isWrap, {name, " step"});
    lastLed = newLed;
  endtask

  task automatic pushLoad(input logic r, input logic [1:0] m, input logic [N-1:0] l);
    vecs.push_back(mkVec(r, m, 1'b1, 1'b0, l, 1'b0, 1'b0));
    lastLed = l;
  endtask

  task automatic pushStep(input logic [1:0] m, input logic [N-1:0] l, input logic w);
    for (int i = 0; i < DIV - 1; i++) vecs.push_back(mkVec(1'b0, m, 1'b1, 1'b0, lastLed, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, m, 1'b1, 1'b0, l, 1'b1, w));
    lastLed = l;
  endtask

  initial begin
    logic       r, rn, sr;
    logic [1:0] m;

    // Free-running tables: ROT_L from reset, then BOUNCE, then COUNT.
    pushLoad(1'b1, 2'd0, 4'b0001);
    for (int s = 0; s < 4; s++) pushStep(2'd0, rotSeq[s], s == 3);
    pushLoad(1'b0, 2'd2, 4'b0001);
    for (int s = 0; s < 6; s++) pushStep(2'd2, bncSeq[s], s == 5);
    pushLoad(1'b0, 2'd3, 4'b0000);
    for (int s = 1; s <= 16; s++) pushStep(2'd3, N'(s % 16), s == 16);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].mode, vecs[i].run, vecs[i].stepReq);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].led, vecs[i].tick, vecs[i].wrap);
    end

    // Single-step while paused: short and long pulses each give one step.
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, "step load");
    cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, "step short");
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, "step short release");
    cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, "step long first");
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, "step long held");
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, "step long release");
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, "step held in run");
    for (int i = 0; i < 2; i++) cyc(1'b0, 2'd1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, "step stale edge");
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, "step idle");

    // Mode change mid-count restarts the new pattern and the divider.
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "chg load rotl");
    lastLed = 4'b0001;
    runStep(2'd0, 4'b0010, 1'b0, "chg rotl");
    runStep(2'd0, 4'b0100, 1'b0, "chg rotl");
    for (int i = 0; i < 2; i++) cyc(1'b0, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, "chg midcount");
    cyc(1'b0, 2'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "chg to count");
    lastLed = 4'b0000;
    runStep(2'd3, 4'b0001, 1'b0, "chg count");

    // Reset in BOUNCE while sweeping down restarts upward from bit 0.
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "rst load bounce");
    lastLed = 4'b0001;
    runStep(2'd2, 4'b0010, 1'b0, "rst bounce");
    runStep(2'd2, 4'b0100, 1'b0, "rst bounce");
    runStep(2'd2, 4'b1000, 1'b0, "rst bounce");
    runStep(2'd2, 4'b0100, 1'b0, "rst bounce down");
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, "rst midcount");
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "rst pulse");
    lastLed = 4'b0001;
    runStep(2'd2, 4'b0010, 1'b0, "rst after");
    runStep(2'd2, 4'b0100, 1'b0, "rst after");

    // Randomized traffic against the step-index model.
    m = 2'd0; rn = 1'b1;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) rn = ~rn;
      sr = ($urandom_range(0, 2) == 0);
      applyStimulus(r, m, rn, sr);
      checkOutput($sformatf("rand[%0d]", i), patternAt(mMode, mK), mTick, mWrap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer for board bring-up and heartbeat indication. Generalises the fixed 4-LED, 1 Hz one-hot rotator to N LEDs with a configurable step rate and four selectable patterns. It also adds run/pause, single-step, and step/wrap status strobes. It sits directly behind the board clock input and drives the LED pins. A simulation-mode parameter shortens the divider for fast benches.

Parameters:
NUM_LEDS, 4, LED count; legal range 2..32.
CLK_HZ, 100000000, input clock frequency in Hz.
STEP_HZ, 1, pattern step rate in Hz; CLK_HZ/STEP_HZ must be >= 2.
SIM_MODE, 0, when 1 the divider period is SIM_DIV instead of CLK_HZ/STEP_HZ.
SIM_DIV, 10, divider period in clocks when SIM_MODE=1; must be >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
mode  input  2  pattern select: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 COUNT.
run  input  1  1 = free-running steps from the divider; 0 = paused.
step_req  input  1  single-step request; honoured only while run=0.
led  output  NUM_LEDS  pattern output; registered.
tick  output  1  one-cycle strobe in the cycle led shows a new step value.
wrap  output  1  one-cycle strobe in the cycle led returns to the start value.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- DIV = SIM_MODE ? SIM_DIV : CLK_HZ/STEP_HZ. The divider counter width is clog2(DIV).
- Divider behaviour:
  - While run=1, the counter counts 0..DIV-1 and wraps to 0.
  - When count==DIV-1, the internal advance (adv) is asserted.
  - While run=0, the counter is held at 0.
- Single-step: step_req is registered. adv is also asserted for one cycle on a detected step_req rising edge while run=0. A step_req high while run=1 is ignored, and its edge is not remembered.
- Start value: 1 for modes 0-2; 0 for COUNT.
- Step rules on adv, for NUM_LEDS = N:
  - ROT_L: led <= {led[N-2:0], led[N-1]}.
  - ROT_R: led <= {led[0], led[N-1:1]}.
  - BOUNCE: the one-hot bit moves toward the MSB while dir=up. On reaching bit N-1, dir flips and the next step goes to bit N-2. On reaching bit 0, dir flips back to up. No bit is ever held for two steps.
  - COUNT: N-bit binary increment; all-ones wraps to 0.
- Mode change:
  - mode is registered into mode_q. When mode differs from mode_q, on the next edge led loads the new mode's start value, dir is set to up, and the counter clears to 0.
  - tick and wrap are 0 on that edge.
  - A mode change overrides a coincident adv.
- Output timing:
  - led updates on the edge where adv=1. tick is high for exactly the following cycle, aligned with the new led value.
  - wrap is high in the same cycle as tick when the new led equals the start value. In BOUNCE this means only the return to bit 0, once per 2N-2 steps.
  - tick and wrap are never asserted without a led change.
- Reset values:
  - led = start value of the mode input sampled at reset; mode_q = mode.
  - dir = up; counter = 0; step_req_q = 0; tick = 0; wrap = 0.
  - Reset overrides all other activity, including reset asserted mid-count or mid-sweep.
- Pause/resume: dropping run freezes led at its current value and clears the counter. Raising run restarts the count from 0, so the first step follows DIV clocks later.
- Edge cases:
  - N=2 BOUNCE: 01->10->01, and wrap fires on every return to 01.
  - N=32 COUNT: full 32-bit wrap is supported.

Test Plan:
Bench configuration: NUM_LEDS=4, SIM_MODE=1, SIM_DIV=4.
1. Reset with mode=0, run=1 -> led=0001. tick every 4 clocks; led sequence 0010, 0100, 1000, 0001; wrap only with 0001.
2. mode=2, run=1 -> led sequence 0010, 0100, 1000, 0100, 0010, 0001. wrap only on 0001, i.e. every 6 steps.
3. mode=3, run=1 -> led counts 0000..1111 then 0000. wrap on 0000 after 16 ticks; tick period 4 clocks throughout.
4. run=0 with step_req pulses lasting 1 and 5 cycles (mode 1) -> exactly one step each: 0001->1000->0100. A step_req held while run=1 causes no extra step.
5. Switch mode 0->3 mid-count with led=0100 -> led=0000 one cycle after the change, no tick/wrap on that edge, and the next tick 4 clocks later with led=0001.
6. Assert reset for 1 cycle mid-sweep in BOUNCE with dir=down at led=0100 -> led=0001, tick=wrap=0. The next steps are 0010, 0100 (dir=up).
